alu_issue_q: RTL

Command queue and result collector wrapped around the two-stage ALU. Upstream requesters push operations over a valid/ready handshake; the block buffers them, issues at most one per cycle into the ALU's register-in/register-out pipeline, and tracks each issue through the fixed ALU latency. Each returning result is captured into a result FIFO drained by a downstream valid/ready consumer. Credit-based issue guarantees a returning result always has a slot, since the ALU has no backpressure.

---
 rtl/alu_pkg.sv | 17 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/alu_issue_q.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg: operation encoding and default latency shared with the ALU |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } operation_t;

  localparam int c_alu_lat = 2;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO, head reads as zero while empty         |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == c_cw'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_cw'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_cw'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_q.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_issue_q: credit-gated command queue and result collector for ALU |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module alu_issue_q
  import alu_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = c_alu_lat
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  operation_t       s_op,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  output operation_t       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_valid,
  input  logic [WIDTH-1:0] alu_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  localparam int c_cmd_w  = 2 + 2 * WIDTH;
  localparam int c_cred_w = $clog2(RES_DEPTH + 1);

  logic [c_cmd_w-1:0]  w_cmd_head;
  logic                w_cmd_full;
  logic                w_cmd_empty;
  logic                w_cmd_push;
  logic                w_issue;
  operation_t          w_head_op;
  logic [WIDTH-1:0]    w_head_a;
  logic [WIDTH-1:0]    w_head_b;
  logic                w_res_empty;
  logic                w_res_full;
  logic                w_m_fire;
  logic                r_live;
  logic [c_cred_w-1:0] r_credits;
  logic [ALU_LAT-1:0]  r_trk;

  // r_live holds s_ready low for the first cycle after reset releases.
  assign s_ready    = r_live && !w_cmd_full;
  assign w_cmd_push = s_valid && s_ready;
  assign w_head_op  = operation_t'(w_cmd_head[c_cmd_w-1 -: 2]);
  assign w_head_a   = w_cmd_head[2*WIDTH-1 -: WIDTH];
  assign w_head_b   = w_cmd_head[WIDTH-1:0];
  assign w_issue    = !w_cmd_empty && (r_credits != '0);
  assign m_valid    = !w_res_empty;
  assign w_m_fire   = m_valid && m_ready;

  sync_fifo #(.WIDTH(c_cmd_w), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_cmd_push),
    .push_data ({s_op, s_a, s_b}),
    .pop       (w_issue),
    .head      (w_cmd_head),
    .full      (w_cmd_full),
    .empty     (w_cmd_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_live    <= 1'b0;
      r_credits <= c_cred_w'(RES_DEPTH);
      alu_valid <= 1'b0;
      alu_op    <= OP_NOP;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_issue && !w_m_fire)      r_credits <= r_credits - c_cred_w'(1);
      else if (!w_issue && w_m_fire) r_credits <= r_credits + c_cred_w'(1);
      alu_valid <= w_issue;
      alu_op    <= w_issue ? w_head_op : OP_NOP;
      alu_a     <= w_issue ? w_head_a  : '0;
      alu_b     <= w_issue ? w_head_b  : '0;
    end
  end

  generate
    if (ALU_LAT == 1) begin : g_trk_single
      always_ff @(posedge clk) begin
        if (!rst) r_trk <= '0;
        else      r_trk <= alu_valid;
      end
    end else begin : g_trk_shift
      always_ff @(posedge clk) begin
        if (!rst) r_trk <= '0;
        else      r_trk <= {r_trk[ALU_LAT-2:0], alu_valid};
      end
    end
  endgenerate

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_trk[ALU_LAT-1]),
    .push_data (alu_out),
    .pop       (w_m_fire),
    .head      (m_data),
    .full      (w_res_full),
    .empty     (w_res_empty)
  );

  // Credits make a returning result meeting a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst) assert (!(r_trk[ALU_LAT-1] && w_res_full));
  end

endmodule
`default_nettype wire
